// File: rtl/status_flag_unit.sv
// EXE-stage ALU and NZCV status register for the condition checker in ID.
// The status_fwd bypass lets a conditional directly behind an S instruction see fresh flags.
module status_flag_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       exe_cmd,
    input  logic [WIDTH-1:0] val1,
    input  logic [WIDTH-1:0] val2,
    input  logic             s_en,
    input  logic             valid,
    input  logic             freeze,
    input  logic             flush,
    output logic [WIDTH-1:0] alu_res,
    output logic [3:0]       status,
    output logic [3:0]       status_fwd,
    output logic             flags_wr
);

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;

    localparam int MSB = WIDTH - 1;

    logic [3:0]       r_status;
    logic             r_flags_wr;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_cin_ext;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_opb;
    logic             w_legal;
    logic             w_arith;
    logic             w_n;
    logic             w_z;
    logic             w_c;
    logic             w_v;
    logic [3:0]       w_flags;
    logic             w_we;

    // Carry-in always comes from the registered C, never the bypass.
    assign w_cin_ext = {{WIDTH{1'b0}}, r_status[1]};

    always_comb begin
        w_sum   = '0;
        w_res   = '0;
        w_opb   = val2;
        w_legal = 1'b0;
        w_arith = 1'b0;
        case (exe_cmd)
            CMD_MOV: begin
                w_legal = 1'b1;
                w_res   = val2;
            end
            CMD_MVN: begin
                w_legal = 1'b1;
                w_res   = ~val2;
            end
            CMD_ADD: begin
                w_legal = 1'b1;
                w_arith = 1'b1;
                w_sum   = {1'b0, val1} + {1'b0, val2};
            end
            CMD_ADC: begin
                w_legal = 1'b1;
                w_arith = 1'b1;
                w_sum   = {1'b0, val1} + {1'b0, val2} + w_cin_ext;
            end
            CMD_SUB: begin
                w_legal = 1'b1;
                w_arith = 1'b1;
                w_opb   = ~val2;
                w_sum   = {1'b0, val1} + {1'b0, ~val2}
                        + {{WIDTH{1'b0}}, 1'b1};
            end
            CMD_SBC: begin
                w_legal = 1'b1;
                w_arith = 1'b1;
                w_opb   = ~val2;
                w_sum   = {1'b0, val1} + {1'b0, ~val2} + w_cin_ext;
            end
            CMD_AND: begin
                w_legal = 1'b1;
                w_res   = val1 & val2;
            end
            CMD_ORR: begin
                w_legal = 1'b1;
                w_res   = val1 | val2;
            end
            CMD_EOR: begin
                w_legal = 1'b1;
                w_res   = val1 ^ val2;
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
        if (w_arith) begin
            w_res = w_sum[WIDTH-1:0];
        end
    end

    // Subtraction feeds ~val2 into the adder, so one overflow rule covers both.
    assign w_n = w_res[MSB];
    assign w_z = ~|w_res;
    assign w_c = w_arith ? w_sum[WIDTH] : r_status[1];
    assign w_v = w_arith
               ? ((val1[MSB] == w_opb[MSB]) & (w_res[MSB] != val1[MSB]))
               : r_status[0];

    assign w_flags = {w_n, w_z, w_c, w_v};
    assign w_we    = s_en & valid & ~freeze & ~flush & w_legal;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_status   <= 4'b0000;
            r_flags_wr <= 1'b0;
        end else begin
            r_flags_wr <= w_we;
            if (w_we) begin
                r_status <= w_flags;
            end
        end
    end

    assign alu_res    = w_res;
    assign status     = r_status;
    assign status_fwd = w_we ? w_flags : r_status;
    assign flags_wr   = r_flags_wr;

endmodule

// File: tb/tb_status_flag_unit.sv
// Directed bench for status_flag_unit: integer-arithmetic reference model
// checked every cycle, plus literal expectations along the test plan.
module tb_status_flag_unit;

    logic        clk;
    logic        rst;
    logic [3:0]  exe_cmd;
    logic [31:0] val1;
    logic [31:0] val2;
    logic        s_en;
    logic        valid;
    logic        freeze;
    logic        flush;
    logic [31:0] alu_res;
    logic [3:0]  status;
    logic [3:0]  status_fwd;
    logic        flags_wr;

    int n_chk;
    int n_fail;

    logic [3:0] m_status;
    logic       m_wr;
    logic       m_known;

    status_flag_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .exe_cmd    (exe_cmd),
        .val1       (val1),
        .val2       (val2),
        .s_en       (s_en),
        .valid      (valid),
        .freeze     (freeze),
        .flush      (flush),
        .alu_res    (alu_res),
        .status     (status),
        .status_fwd (status_fwd),
        .flags_wr   (flags_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain wide-integer arithmetic on unsigned and signed values.
    task automatic model(
        input  logic [3:0]  cmd,
        input  logic [31:0] a,
        input  logic [31:0] b,
        input  logic [3:0]  st,
        output logic [31:0] res,
        output logic        legal,
        output logic [3:0]  nf
    );
        longint ua, ub, sa, sb, u, s, cin, brw;
        logic c, v;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        cin = st[1] ? 64'sd1 : 64'sd0;
        brw = 64'sd1 - cin;
        c = st[1];
        v = st[0];
        legal = 1'b1;
        res = 32'h0;
        case (cmd)
            4'd1: res = b;
            4'd9: res = ~b;
            4'd6: res = a & b;
            4'd7: res = a | b;
            4'd8: res = a ^ b;
            4'd2, 4'd3: begin
                u = ua + ub + ((cmd == 4'd3) ? cin : 64'sd0);
                s = sa + sb + ((cmd == 4'd3) ? cin : 64'sd0);
                res = u[31:0];
                c = (u > 64'sd4294967295);
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd4, 4'd5: begin
                u = ua - ub - ((cmd == 4'd5) ? brw : 64'sd0);
                s = sa - sb - ((cmd == 4'd5) ? brw : 64'sd0);
                res = u[31:0];
                c = (u >= 0);
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            default: legal = 1'b0;
        endcase
        nf = {res[31], res == 32'h0, c, v};
    endtask

    function automatic logic model_we(input logic legal);
        return s_en && valid && !freeze && !flush && legal;
    endfunction

    always @(posedge clk) begin
        logic [31:0] r;
        logic        lg;
        logic [3:0]  nf;
        model(exe_cmd, val1, val2, m_status, r, lg, nf);
        if (rst) begin
            m_status = 4'b0000;
            m_wr     = 1'b0;
            m_known  = 1'b1;
        end else begin
            m_wr = model_we(lg);
            if (m_wr) m_status = nf;
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] r;
        logic        lg;
        logic [3:0]  nf;
        if (m_known) begin
            model(exe_cmd, val1, val2, m_status, r, lg, nf);
            check("model alu_res", alu_res, r);
            check("model status", {28'h0, status}, {28'h0, m_status});
            check("model status_fwd", {28'h0, status_fwd},
                  {28'h0, model_we(lg) ? nf : m_status});
            check("model flags_wr", {31'h0, flags_wr}, {31'h0, m_wr});
        end
    end

    task automatic set_in(input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b);
        exe_cmd = c;
        val1    = a;
        val2    = b;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        m_known = 1'b0;
        m_status = 4'b0000;
        m_wr     = 1'b0;
        rst    = 1'b1;
        s_en   = 1'b1;
        valid  = 1'b1;
        freeze = 1'b0;
        flush  = 1'b0;
        set_in(4'd2, 32'd1, 32'd1);

        tick;
        check("reset status 1", {28'h0, status}, 32'h0);
        check("reset flags_wr 1", {31'h0, flags_wr}, 32'h0);
        tick;
        check("reset status 2", {28'h0, status}, 32'h0);
        check("reset flags_wr 2", {31'h0, flags_wr}, 32'h0);
        rst = 1'b0;
        tick;
        check("post-reset add status", {28'h0, status}, 32'h0);
        check("post-reset add wr", {31'h0, flags_wr}, 32'h1);

        set_in(4'd2, 32'h7FFFFFFF, 32'h1);
        #1;
        check("add ovf alu", alu_res, 32'h80000000);
        check("add ovf fwd", {28'h0, status_fwd}, 32'h9);
        tick;
        check("add ovf status", {28'h0, status}, 32'h9);
        check("add ovf wr", {31'h0, flags_wr}, 32'h1);

        set_in(4'd4, 32'd5, 32'd5);
        #1;
        check("cmp alu", alu_res, 32'h0);
        tick;
        check("cmp status", {28'h0, status}, 32'h6);
        set_in(4'd5, 32'd3, 32'd1);
        #1;
        check("sbc alu", alu_res, 32'd2);
        tick;
        check("sbc status", {28'h0, status}, 32'h2);
        set_in(4'd4, 32'd1, 32'd2);
        #1;
        check("sub neg alu", alu_res, 32'hFFFFFFFF);
        tick;
        check("sub neg status", {28'h0, status}, 32'h8);

        set_in(4'd2, 32'h80000000, 32'hFFFFFFFF);
        tick;
        check("add cv status", {28'h0, status}, 32'h3);
        set_in(4'd3, 32'hFFFFFFFF, 32'h0);
        #1;
        check("adc alu", alu_res, 32'h0);
        tick;
        check("adc status", {28'h0, status}, 32'h6);
        set_in(4'd6, 32'h80000000, 32'hFFFFFFFF);
        tick;
        check("and keep cv", {28'h0, status}, 32'hA);

        set_in(4'd2, 32'h7FFFFFFF, 32'h1);
        freeze = 1'b1;
        #1;
        check("freeze fwd", {28'h0, status_fwd}, 32'hA);
        tick;
        check("freeze status", {28'h0, status}, 32'hA);
        check("freeze wr", {31'h0, flags_wr}, 32'h0);
        freeze = 1'b0;
        flush  = 1'b1;
        tick;
        check("flush status", {28'h0, status}, 32'hA);
        flush = 1'b0;
        valid = 1'b0;
        tick;
        check("bubble status", {28'h0, status}, 32'hA);
        valid = 1'b1;
        s_en  = 1'b0;
        tick;
        check("no-s status", {28'h0, status}, 32'hA);
        check("no-s wr", {31'h0, flags_wr}, 32'h0);
        s_en = 1'b1;
        set_in(4'hF, 32'h7FFFFFFF, 32'h1);
        #1;
        check("illegal alu", alu_res, 32'h0);
        tick;
        check("illegal status", {28'h0, status}, 32'hA);
        set_in(4'd2, 32'h7FFFFFFF, 32'h1);
        freeze = 1'b1;
        flush  = 1'b1;
        tick;
        check("frz+flush status", {28'h0, status}, 32'hA);
        flush = 1'b0;
        tick;
        check("frz held status", {28'h0, status}, 32'hA);
        freeze = 1'b0;
        tick;
        check("release status", {28'h0, status}, 32'h9);

        set_in(4'd4, 32'd0, 32'd1);
        rst = 1'b1;
        tick;
        check("rst pulse status", {28'h0, status}, 32'h0);
        check("rst pulse wr", {31'h0, flags_wr}, 32'h0);
        rst = 1'b0;
        tick;
        check("sub 0-1 status", {28'h0, status}, 32'h8);

        set_in(4'd9, 32'h0, 32'hFFFFFFFF);
        tick;
        check("mvn zero status", {28'h0, status}, 32'h4);

        // Sweep every opcode over a few operand pairs; the model checks each cycle.
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 16; c++) begin
                case (k)
                    0: set_in(4'(c), 32'hFFFFFFFF, 32'h00000001);
                    1: set_in(4'(c), 32'h80000000, 32'h00000001);
                    2: set_in(4'(c), 32'h12345678, 32'h87654321);
                    default: set_in(4'(c), 32'h00000000, 32'h00000000);
                endcase
                s_en = (c % 5) != 4;
                tick;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
